// File: rtl/idu_pkg.sv
// Shared decoder definitions: opcodes, one-hot bit indices, operand select
// encodings and the decoded control bundle carried through the skid buffer.
package idu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ALU_W  = 10;
  localparam int unsigned OH8_W  = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [INST_W-1:0] INST_EBREAK = 32'h0010_0073;

  localparam int unsigned ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3, ALU_AND = 4;
  localparam int unsigned ALU_OR  = 5, ALU_XOR = 6, ALU_SLL = 7, ALU_SRL  = 8, ALU_SRA = 9;

  localparam int unsigned JMP_JAL = 0, JMP_JALR = 1, JMP_BEQ  = 2, JMP_BNE  = 3;
  localparam int unsigned JMP_BLT = 4, JMP_BGE  = 5, JMP_BLTU = 6, JMP_BGEU = 7;

  localparam int unsigned MEM_SB = 0, MEM_SH = 1, MEM_SW  = 2, MEM_LB  = 3;
  localparam int unsigned MEM_LH = 4, MEM_LW = 5, MEM_LBU = 6, MEM_LHU = 7;

  localparam logic [SEL_W-1:0] SRC1_RS1  = 3'b001;
  localparam logic [SEL_W-1:0] SRC1_PC   = 3'b010;
  localparam logic [SEL_W-1:0] SRC1_ZERO = 3'b100;
  localparam logic [SEL_W-1:0] SRC2_RS2  = 3'b001;
  localparam logic [SEL_W-1:0] SRC2_IMM  = 3'b010;
  localparam logic [SEL_W-1:0] SRC2_FOUR = 3'b100;

  // Control fields only; pc/imm are XLEN-wide and carried beside the bundle.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [ALU_W-1:0] alu_op;
    logic [OH8_W-1:0] mdu_op;
    logic [OH8_W-1:0] jump_type;
    logic [OH8_W-1:0] mem_type;
    logic [SEL_W-1:0] sel_alu_src1;
    logic [SEL_W-1:0] sel_alu_src2;
    logic             rf_wen;
    logic             sel_rf_wdata;
    logic             dram_en;
    logic             dram_wen;
    logic             ebreak;
    logic             illegal;
  } dec_bundle_t;

  // ALU one-hot for OP/OP-IMM by funct3; alt selects sub/sra.
  function automatic logic [ALU_W-1:0] alu_onehot(input logic [2:0] f3, input logic alt);
    logic [ALU_W-1:0] oh;
    oh = '0;
    case (f3)
      3'b000:  oh[alt ? ALU_SUB : ALU_ADD] = 1'b1;
      3'b001:  oh[ALU_SLL]  = 1'b1;
      3'b010:  oh[ALU_SLT]  = 1'b1;
      3'b011:  oh[ALU_SLTU] = 1'b1;
      3'b100:  oh[ALU_XOR]  = 1'b1;
      3'b101:  oh[alt ? ALU_SRA : ALU_SRL] = 1'b1;
      3'b110:  oh[ALU_OR]   = 1'b1;
      default: oh[ALU_AND]  = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/idu_pipe_if.sv
// IFU->IDU->EXU handshake bundle. master: IFU/EXU side, slave: decoder.
interface idu_pipe_if
  import idu_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_imm;
  logic [REG_W-1:0]  out_rd;
  logic [REG_W-1:0]  out_rs1;
  logic [REG_W-1:0]  out_rs2;
  logic [ALU_W-1:0]  out_alu_op;
  logic [OH8_W-1:0]  out_mdu_op;
  logic [OH8_W-1:0]  out_jump_type;
  logic [OH8_W-1:0]  out_mem_type;
  logic [SEL_W-1:0]  out_sel_alu_src1;
  logic [SEL_W-1:0]  out_sel_alu_src2;
  logic              out_rf_wen;
  logic              out_sel_rf_wdata;
  logic              out_dram_en;
  logic              out_dram_wen;
  logic              out_ebreak;
  logic              out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
           out_alu_op, out_mdu_op, out_jump_type, out_mem_type,
           out_sel_alu_src1, out_sel_alu_src2, out_rf_wen, out_sel_rf_wdata,
           out_dram_en, out_dram_wen, out_ebreak, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
           out_alu_op, out_mdu_op, out_jump_type, out_mem_type,
           out_sel_alu_src1, out_sel_alu_src2, out_rf_wen, out_sel_rf_wdata,
           out_dram_en, out_dram_wen, out_ebreak, out_illegal
  );
endinterface

// File: rtl/idu_dec.sv
// Combinational RV32I(+M, ebreak) decoder.
// inst: instruction word; dec_c: control bundle; imm_c: XLEN sign-extended immediate.
module idu_dec
  import idu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b1
) (
  input  logic [INST_W-1:0] inst,
  output dec_bundle_t       dec_c,
  output logic [XLEN-1:0]   imm_c
);

  logic [6:0]      opcode, funct7;
  logic [5:0]      funct6;
  logic [2:0]      funct3;
  logic            shamt_ok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign funct6 = inst[31:26];
  // inst[25] is shamt[5] on RV64 but must be zero on RV32.
  assign shamt_ok = (XLEN == 32) ? ~inst[25] : 1'b1;

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    dec_c              = '0;
    imm_c              = '0;
    dec_c.rd           = inst[11:7];
    dec_c.rs1          = inst[19:15];
    dec_c.rs2          = inst[24:20];
    dec_c.sel_alu_src1 = SRC1_RS1;
    dec_c.sel_alu_src2 = SRC2_RS2;

    case (opcode)
      OPC_LUI: begin
        imm_c                  = imm_u;
        dec_c.alu_op[ALU_ADD]  = 1'b1;
        dec_c.sel_alu_src1     = SRC1_ZERO;
        dec_c.sel_alu_src2     = SRC2_IMM;
        dec_c.rf_wen           = 1'b1;
      end
      OPC_AUIPC: begin
        imm_c                  = imm_u;
        dec_c.alu_op[ALU_ADD]  = 1'b1;
        dec_c.sel_alu_src1     = SRC1_PC;
        dec_c.sel_alu_src2     = SRC2_IMM;
        dec_c.rf_wen           = 1'b1;
      end
      OPC_JAL: begin
        imm_c                  = imm_j;
        dec_c.alu_op[ALU_ADD]  = 1'b1;
        dec_c.jump_type[JMP_JAL] = 1'b1;
        dec_c.sel_alu_src1     = SRC1_PC;
        dec_c.sel_alu_src2     = SRC2_FOUR;
        dec_c.rf_wen           = 1'b1;
      end
      OPC_JALR: begin
        imm_c                  = imm_i;
        dec_c.alu_op[ALU_ADD]  = 1'b1;
        dec_c.jump_type[JMP_JALR] = 1'b1;
        dec_c.sel_alu_src1     = SRC1_PC;
        dec_c.sel_alu_src2     = SRC2_FOUR;
        dec_c.rf_wen           = 1'b1;
        dec_c.illegal          = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm_c                  = imm_b;
        dec_c.alu_op[ALU_ADD]  = 1'b1;
        case (funct3)
          3'b000:  dec_c.jump_type[JMP_BEQ]  = 1'b1;
          3'b001:  dec_c.jump_type[JMP_BNE]  = 1'b1;
          3'b100:  dec_c.jump_type[JMP_BLT]  = 1'b1;
          3'b101:  dec_c.jump_type[JMP_BGE]  = 1'b1;
          3'b110:  dec_c.jump_type[JMP_BLTU] = 1'b1;
          3'b111:  dec_c.jump_type[JMP_BGEU] = 1'b1;
          default: dec_c.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm_c                  = imm_i;
        dec_c.alu_op[ALU_ADD]  = 1'b1;
        dec_c.sel_alu_src2     = SRC2_IMM;
        dec_c.dram_en          = 1'b1;
        dec_c.sel_rf_wdata     = 1'b1;
        dec_c.rf_wen           = 1'b1;
        case (funct3)
          3'b000:  dec_c.mem_type[MEM_LB]  = 1'b1;
          3'b001:  dec_c.mem_type[MEM_LH]  = 1'b1;
          3'b010:  dec_c.mem_type[MEM_LW]  = 1'b1;
          3'b100:  dec_c.mem_type[MEM_LBU] = 1'b1;
          3'b101:  dec_c.mem_type[MEM_LHU] = 1'b1;
          default: dec_c.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        imm_c                  = imm_s;
        dec_c.alu_op[ALU_ADD]  = 1'b1;
        dec_c.sel_alu_src2     = SRC2_IMM;
        dec_c.dram_en          = 1'b1;
        dec_c.dram_wen         = 1'b1;
        case (funct3)
          3'b000:  dec_c.mem_type[MEM_SB] = 1'b1;
          3'b001:  dec_c.mem_type[MEM_SH] = 1'b1;
          3'b010:  dec_c.mem_type[MEM_SW] = 1'b1;
          default: dec_c.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        imm_c              = imm_i;
        dec_c.alu_op       = alu_onehot(funct3, (funct3 == 3'b101) & inst[30]);
        dec_c.sel_alu_src2 = SRC2_IMM;
        dec_c.rf_wen       = 1'b1;
        if (funct3 == 3'b001)
          dec_c.illegal = (funct6 != 6'b000000) | ~shamt_ok;
        else if (funct3 == 3'b101)
          dec_c.illegal = ((funct6 != 6'b000000) & (funct6 != 6'b010000)) | ~shamt_ok;
      end
      OPC_OP: begin
        dec_c.rf_wen = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (EN_M) dec_c.mdu_op[funct3] = 1'b1;
          else      dec_c.illegal        = 1'b1;
        end else if (funct7 == 7'b0000000) begin
          dec_c.alu_op = alu_onehot(funct3, 1'b0);
        end else if ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          dec_c.alu_op = alu_onehot(funct3, 1'b1);
        end else begin
          dec_c.illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        imm_c = imm_i;
        if (inst == INST_EBREAK) dec_c.ebreak  = 1'b1;
        else                     dec_c.illegal = 1'b1;
      end
      default: dec_c.illegal = 1'b1;
    endcase

    // Illegal entries travel as inert bubbles flagged for the trap path.
    if (dec_c.illegal) begin
      dec_c.alu_op       = '0;
      dec_c.mdu_op       = '0;
      dec_c.jump_type    = '0;
      dec_c.mem_type     = '0;
      dec_c.rf_wen       = 1'b0;
      dec_c.sel_rf_wdata = 1'b0;
      dec_c.dram_en      = 1'b0;
      dec_c.dram_wen     = 1'b0;
      dec_c.ebreak       = 1'b0;
    end
    if (dec_c.rd == 5'd0) dec_c.rf_wen = 1'b0;
  end

endmodule

// File: rtl/idu_pipe.sv
// Registered decode stage with a 2-entry skid buffer between IFU and EXU.
// clk/rst_n: clock, async active-low reset; flush: drop buffered and incoming entries;
// bus: in_* from IFU (valid/ready), out_* decoded head entry to EXU (valid/ready).
module idu_pipe
  import idu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  idu_pipe_if.slave     bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t          state, state_nxt;
  dec_bundle_t     dec_c, h_dec, s_dec;
  logic [XLEN-1:0] imm_c, h_imm, s_imm, h_pc, s_pc;
  logic            in_ready_q, out_valid_q;
  logic            accept_c, pop_c, load_h_in_c, load_h_skid_c, load_s_c;

  idu_dec #(.XLEN(XLEN), .EN_M(EN_M)) u_dec (
    .inst  (bus.in_inst),
    .dec_c (dec_c),
    .imm_c (imm_c)
  );

  assign accept_c = bus.in_valid & in_ready_q;
  assign pop_c    = out_valid_q & bus.out_ready;

  // Next-state and register load enables.
  always_comb begin
    state_nxt     = state;
    load_h_in_c   = 1'b0;
    load_h_skid_c = 1'b0;
    load_s_c      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept_c) begin
          state_nxt   = ST_ONE;
          load_h_in_c = 1'b1;
        end
        ST_ONE: begin
          if (accept_c && pop_c) begin
            load_h_in_c = 1'b1;
          end else if (accept_c) begin
            state_nxt = ST_TWO;
            load_s_c  = 1'b1;
          end else if (pop_c) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: if (pop_c) begin
          state_nxt     = ST_ONE;
          load_h_skid_c = 1'b1;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State plus handshake flags, registered from next state so out_ready/flush never reach in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != ST_TWO);
      out_valid_q <= (state_nxt != ST_EMPTY);
    end
  end

  // Head (H) and skid (S) entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_dec <= '0;
      h_imm <= '0;
      h_pc  <= '0;
      s_dec <= '0;
      s_imm <= '0;
      s_pc  <= '0;
    end else begin
      if (load_h_in_c) begin
        h_dec <= dec_c;
        h_imm <= imm_c;
        h_pc  <= bus.in_pc;
      end else if (load_h_skid_c) begin
        h_dec <= s_dec;
        h_imm <= s_imm;
        h_pc  <= s_pc;
      end
      if (load_s_c) begin
        s_dec <= dec_c;
        s_imm <= imm_c;
        s_pc  <= bus.in_pc;
      end
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_pc           = h_pc;
  assign bus.out_imm          = h_imm;
  assign bus.out_rd           = h_dec.rd;
  assign bus.out_rs1          = h_dec.rs1;
  assign bus.out_rs2          = h_dec.rs2;
  assign bus.out_alu_op       = h_dec.alu_op;
  assign bus.out_mdu_op       = h_dec.mdu_op;
  assign bus.out_jump_type    = h_dec.jump_type;
  assign bus.out_mem_type     = h_dec.mem_type;
  assign bus.out_sel_alu_src1 = h_dec.sel_alu_src1;
  assign bus.out_sel_alu_src2 = h_dec.sel_alu_src2;
  assign bus.out_rf_wen       = h_dec.rf_wen;
  assign bus.out_sel_rf_wdata = h_dec.sel_rf_wdata;
  assign bus.out_dram_en      = h_dec.dram_en;
  assign bus.out_dram_wen     = h_dec.dram_wen;
  assign bus.out_ebreak       = h_dec.ebreak;
  assign bus.out_illegal      = h_dec.illegal;

endmodule
